// File: rtl/writeback_arbiter_pkg.sv
// Shared widths and result-source encoding for the register file writeback path.
package writeback_arbiter_pkg;
   localparam int B_WORD = 32;
   localparam int N_REGS = 32;
   localparam int RD_W   = $clog2(N_REGS);

   typedef logic [B_WORD-1:0] word_t;
   typedef logic [RD_W-1:0]   rd_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_LD   = 2'd2,
      SRC_MD   = 2'd3
   } src_t;
endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a long-latency result source, with its
// ready flag and a saturating count of cycles spent waiting for a grant.
module wb_hold_slot
   import writeback_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_cpu,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [RD_W-1:0]   in_rd,
   input  logic [B_WORD-1:0] in_data,
   input  logic              grant,
   output logic              ready,
   output logic              full,
   output logic [RD_W-1:0]   rd,
   output logic [B_WORD-1:0] data,
   output logic              starving,
   output logic              starve_next
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_nxt;

   // Ready depends only on state; reset forces it low while asserted.
   assign ready    = !full && !reset;
   assign starving = (wait_cnt == LIMIT);

   always_comb begin
      wait_nxt = '0;
      if (full && !grant)
         wait_nxt = starving ? LIMIT : wait_cnt + 1'b1;
   end

   assign starve_next = (wait_nxt == LIMIT);

   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
         full     <= 1'b0;
         rd       <= '0;
         data     <= '0;
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_nxt;
         if (in_valid && ready) begin
            full <= 1'b1;
            rd   <= in_rd;
            data <= in_data;
         end else if (grant) begin
            full <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU, load and mul/div results onto the single register file write
// port and tracks outstanding long-latency destinations for decode.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_cpu,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [RD_W-1:0]   alu_rd,
   input  logic [B_WORD-1:0] alu_data,
   output logic              alu_stall,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [RD_W-1:0]   ld_rd,
   input  logic [B_WORD-1:0] ld_data,
   input  logic              md_valid,
   output logic              md_ready,
   input  logic [RD_W-1:0]   md_rd,
   input  logic [B_WORD-1:0] md_data,
   input  logic              issue_en,
   input  logic [RD_W-1:0]   issue_rd,
   output logic              wr_en,
   output logic [RD_W-1:0]   wr_adrs,
   output logic [B_WORD-1:0] wr_data,
   output logic [N_REGS-1:0] pending
);
   src_t              sel;
   logic              ld_full, md_full, ld_starving, md_starving;
   logic              ld_starve_nxt, md_starve_nxt;
   logic [RD_W-1:0]   ld_hold_rd, md_hold_rd, win_rd;
   logic [B_WORD-1:0] ld_hold_data, md_hold_data, win_data;
   logic              wr_long;
   logic [N_REGS-1:0] pend_nxt;

   wb_hold_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_ld_slot (
      .clk_cpu(clk_cpu), .reset(reset),
      .in_valid(ld_valid), .in_rd(ld_rd), .in_data(ld_data),
      .grant(sel == SRC_LD), .ready(ld_ready), .full(ld_full),
      .rd(ld_hold_rd), .data(ld_hold_data),
      .starving(ld_starving), .starve_next(ld_starve_nxt)
   );

   wb_hold_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_md_slot (
      .clk_cpu(clk_cpu), .reset(reset),
      .in_valid(md_valid), .in_rd(md_rd), .in_data(md_data),
      .grant(sel == SRC_MD), .ready(md_ready), .full(md_full),
      .rd(md_hold_rd), .data(md_hold_data),
      .starving(md_starving), .starve_next(md_starve_nxt)
   );

   // A starving mul/div jumps ahead of the load slot; load starvation is
   // relieved only through alu_stall.
   always_comb begin
      sel = SRC_NONE;
      if (alu_valid && !alu_stall)  sel = SRC_ALU;
      else if (md_full && md_starving) sel = SRC_MD;
      else if (ld_full)             sel = SRC_LD;
      else if (md_full)             sel = SRC_MD;
   end

   always_comb begin
      win_rd   = '0;
      win_data = '0;
      case (sel)
         SRC_ALU: begin win_rd = alu_rd;     win_data = alu_data;     end
         SRC_LD:  begin win_rd = ld_hold_rd; win_data = ld_hold_data; end
         SRC_MD:  begin win_rd = md_hold_rd; win_data = md_hold_data; end
         default: ;
      endcase
   end

   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
         wr_en     <= 1'b0;
         wr_adrs   <= '0;
         wr_data   <= '0;
         wr_long   <= 1'b0;
         alu_stall <= 1'b0;
      end else begin
         alu_stall <= ld_starve_nxt || md_starve_nxt;
         wr_en     <= (sel != SRC_NONE) && (win_rd != '0);
         wr_long   <= (sel == SRC_LD) || (sel == SRC_MD);
         if (sel != SRC_NONE) begin
            wr_adrs <= win_rd;
            wr_data <= win_data;
         end
      end
   end

   // Clear lands on the edge the register file captures the write; a
   // same-cycle issue to that register wins.
   always_comb begin
      pend_nxt = pending;
      if (wr_en && wr_long) pend_nxt[wr_adrs] = 1'b0;
      if (issue_en)         pend_nxt[issue_rd] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) pending <= '0;
      else       pending <= pend_nxt;
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench: writes are predicted into a queue and checked by a monitor;
// stall, ready and scoreboard flags are checked inline.
module tb_writeback_arbiter;
   logic        clk_cpu = 1'b0;
   logic        reset;
   logic        alu_valid, ld_valid, md_valid, issue_en;
   logic [4:0]  alu_rd, ld_rd, md_rd, issue_rd;
   logic [31:0] alu_data, ld_data, md_data;
   logic        alu_stall, ld_ready, md_ready, wr_en;
   logic [4:0]  wr_adrs;
   logic [31:0] wr_data, pending;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0]  adrs;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];
   wr_t mon_e;

   always #5 clk_cpu = ~clk_cpu;

   writeback_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk_cpu(clk_cpu), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
      .issue_en(issue_en), .issue_rd(issue_rd),
      .wr_en(wr_en), .wr_adrs(wr_adrs), .wr_data(wr_data), .pending(pending)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_cpu);
      #1;
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   always @(negedge clk_cpu) begin
      if (!reset && wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got adrs %0d data %h expected no write", wr_adrs, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_adrs", 32'(wr_adrs), 32'(mon_e.adrs));
            chk("wr_data", wr_data, mon_e.data);
         end
      end
   end

   initial begin
      reset = 1'b1;
      alu_valid = 0; ld_valid = 0; md_valid = 0; issue_en = 0;
      alu_rd = 0; ld_rd = 0; md_rd = 0; issue_rd = 0;
      alu_data = 0; ld_data = 0; md_data = 0;
      tick();
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_md_ready", 32'(md_ready), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_adrs", 32'(wr_adrs), 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_pending", pending, 32'd0);
      chk("rst_alu_stall", 32'(alu_stall), 32'd0);
      reset = 1'b0;
      tick();

      // ALU single-cycle write
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      push(5, 32'hDEADBEEF);
      tick();
      alu_valid = 0;
      chk("alu_wr_en", 32'(wr_en), 32'd1);
      tick();

      // Issue then load to r7, scoreboard tracking
      issue_en = 1; issue_rd = 7;
      tick();
      issue_en = 0;
      chk("pend7_set", 32'(pending[7]), 32'd1);
      chk("ld_ready_pre", 32'(ld_ready), 32'd1);
      ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
      push(7, 32'h1234);
      tick();
      ld_valid = 0;
      chk("ld_ready_full", 32'(ld_ready), 32'd0);
      chk("pend7_hold", 32'(pending[7]), 32'd1);
      chk("ld_wr_en_early", 32'(wr_en), 32'd0);
      tick();
      chk("ld_wr_en", 32'(wr_en), 32'd1);
      chk("ld_ready_free", 32'(ld_ready), 32'd1);
      chk("pend7_at_write", 32'(pending[7]), 32'd1);
      tick();
      chk("pend7_clr", 32'(pending[7]), 32'd0);
      tick();

      // Simultaneous load and mul/div offers
      ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
      md_valid = 1; md_rd = 4; md_data = 32'h44;
      push(3, 32'h33);
      push(4, 32'h44);
      tick();
      ld_valid = 0; md_valid = 0;
      tick();
      chk("dual_wr1", 32'(wr_adrs), 32'd3);
      tick();
      chk("dual_wr2", 32'(wr_adrs), 32'd4);
      tick();
      tick();

      // Load starved by a continuous ALU stream
      alu_valid = 1; alu_rd = 10; alu_data = 32'hA0;
      ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
      for (int i = 0; i < 5; i++) push(10, 32'hA0);
      push(9, 32'h99);
      push(10, 32'hA0);
      push(10, 32'hA0);
      tick();
      ld_valid = 0;
      chk("stall_e1", 32'(alu_stall), 32'd0);
      tick(); tick(); tick();
      chk("stall_e4", 32'(alu_stall), 32'd0);
      tick();
      chk("stall_e5", 32'(alu_stall), 32'd1);
      tick();
      chk("stall_e6", 32'(alu_stall), 32'd0);
      chk("starved_ld_wr", 32'(wr_adrs), 32'd9);
      tick(); tick();
      alu_valid = 0;
      tick();
      tick();

      // Load to r0 is consumed without a write
      ld_valid = 1; ld_rd = 0; ld_data = 32'h55;
      tick();
      ld_valid = 0;
      chk("r0_ld_ready", 32'(ld_ready), 32'd0);
      tick();
      chk("r0_wr_en", 32'(wr_en), 32'd0);
      chk("r0_ld_free", 32'(ld_ready), 32'd1);
      chk("r0_pending", pending, 32'd0);
      tick();

      // Reset while both slots are full
      ld_valid = 1; ld_rd = 20; ld_data = 32'h2020;
      md_valid = 1; md_rd = 21; md_data = 32'h2121;
      issue_en = 1; issue_rd = 12;
      tick();
      ld_valid = 0; md_valid = 0; issue_en = 0;
      chk("pre_rst_pend12", 32'(pending[12]), 32'd1);
      chk("pre_rst_ld_full", 32'(ld_ready), 32'd0);
      chk("pre_rst_md_full", 32'(md_ready), 32'd0);
      reset = 1'b1;
      #1;
      chk("mid_rst_pending", pending, 32'd0);
      chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
      chk("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("post_rst_md_ready", 32'(md_ready), 32'd1);
      tick();
      chk("post_rst_wr_en", 32'(wr_en), 32'd0);
      chk("post_rst_pending", pending, 32'd0);
      tick();
      tick();

      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
